// File: rtl/bt_uart_rx.sv
// bt_uart_rx: 16x oversampled UART receiver, show-ahead byte FIFO, sticky errors.
// Ports: clk, reset_n, rxd in; out_data/out_valid/out_ready byte stream;
// fifo_count; frame_err, overrun, parity_err; clr_err. Macro: BT_UART_RX_PARITY_EN.
module bt_uart_rx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        rxd,
  output logic [7:0]                  out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        frame_err,
  output logic                        overrun,
  output logic                        parity_err,
  input  logic                        clr_err
);
  localparam int DIV_R = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
  localparam int DIV   = (DIV_R < 1) ? 1 : DIV_R;
  localparam int PW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] PSC_TOP = PW'(DIV - 1);
  localparam logic [AW:0]   FULL    = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT
`ifdef BT_UART_RX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t        state;
  logic          rx_m;
  logic          rxs;
  logic          rxs_q;
  logic [PW-1:0] psc;
  logic          tick;
  logic          mid;
  logic          last;
  logic [3:0]    tc;
  logic [2:0]    bc;
  logic [7:0]    sh;
  logic          good;
  logic          push;
  logic          pop;
  logic          wr_en;
  logic          full;
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [7:0]    mem [FIFO_DEPTH];

  // rxs_q is the previous synchronized level, used only for edge detect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_m  <= 1'b1;
      rxs   <= 1'b1;
      rxs_q <= 1'b1;
    end else begin
      rx_m  <= rxd;
      rxs   <= rx_m;
      rxs_q <= rxs;
    end
  end

  // held at zero in IDLE so bit phase starts at the start edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      psc <= '0;
    else if (state == S_IDLE || psc == PSC_TOP)
      psc <= '0;
    else
      psc <= psc + 1'b1;
  end

  assign tick = (state != S_IDLE) && (psc == PSC_TOP);
  assign mid  = tick && (tc == 4'd7);
  assign last = tick && (tc == 4'd15);

`ifdef BT_UART_RX_PARITY_EN
  logic bad;
  assign good = !bad;
`else
  assign good = 1'b1;
  assign parity_err = 1'b0;
`endif

  assign push = (state == S_STOP) && last && rxs && good;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      tc        <= '0;
      bc        <= '0;
      sh        <= '0;
      frame_err <= 1'b0;
`ifdef BT_UART_RX_PARITY_EN
      bad        <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      if (clr_err) begin
        frame_err <= 1'b0;
`ifdef BT_UART_RX_PARITY_EN
        parity_err <= 1'b0;
`endif
      end
      if (tick)
        tc <= tc + 4'd1;
      unique case (state)
        S_IDLE: begin
          if (rxs_q && !rxs) begin
            tc    <= '0;
            bc    <= '0;
            state <= S_START;
`ifdef BT_UART_RX_PARITY_EN
            bad   <= 1'b0;
`endif
          end
        end
        S_START: begin
          if (mid) begin
            if (rxs) begin
              state <= S_IDLE;
            end else begin
              tc    <= '0;
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (last) begin
            sh <= {rxs, sh[7:1]};
            bc <= bc + 3'd1;
            if (bc == 3'd7) begin
`ifdef BT_UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end
        end
`ifdef BT_UART_RX_PARITY_EN
        S_PARITY: begin
          if (last) begin
            if (^{sh, rxs}) begin
              bad        <= 1'b1;
              parity_err <= 1'b1;
            end
            state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (last) begin
            if (rxs) begin
              state <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (rxs)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign full      = (fifo_count == FULL);
  assign out_valid = (fifo_count != '0);
  assign out_data  = mem[rp];
  assign pop       = out_valid && out_ready;
  // a pop in the same cycle frees the slot a full FIFO would lack
  assign wr_en     = push && (!full || pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp         <= '0;
      rp         <= '0;
      fifo_count <= '0;
      overrun    <= 1'b0;
      mem        <= '{default: '0};
    end else begin
      if (wr_en) begin
        mem[wp] <= sh;
        wp      <= wp + 1'b1;
      end
      if (pop)
        rp <= rp + 1'b1;
      if (wr_en && !pop)
        fifo_count <= fifo_count + 1'b1;
      else if (!wr_en && pop)
        fifo_count <= fifo_count - 1'b1;
      if (clr_err)
        overrun <= 1'b0;
      if (push && !wr_en)
        overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_bt_uart_rx.sv
// tb_bt_uart_rx: randomized frames against a queue-based receiver model.
// DIV=1 (16 clocks per bit); directed scenarios pin the model's timing.
`timescale 1ns/1ps
module tb_bt_uart_rx;
  localparam int DEPTH = 16;
`ifdef BT_UART_RX_PARITY_EN
  localparam int STOP_AT = 171;
`else
  localparam int STOP_AT = 155;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rxd;
  logic       out_ready;
  logic       clr_err;
  logic [7:0] out_data;
  logic       out_valid;
  logic [4:0] fifo_count;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  bt_uart_rx #(
    .CLK_HZ(1600000),
    .BAUD(100000),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rxd(rxd),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .fifo_count(fifo_count),
    .frame_err(frame_err),
    .overrun(overrun),
    .parity_err(parity_err),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // kind: 0 byte delivered, 1 stop bit low, 2 parity mismatch
  typedef struct {
    int         at;
    int         kind;
    logic [7:0] d;
  } ev_t;

  ev_t        ev[$];
  logic [7:0] mq[$];
  logic       mf = 1'b0;
  logic       mo = 1'b0;
  logic       mp = 1'b0;
  int         cyc = 0;
  bit         chk_en = 1'b0;
  bit         rand_on = 1'b0;
  int         rp_pct = 0;
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic add_ev(input int at, input int kind, input logic [7:0] d);
    ev_t e;
    e.at = at;
    e.kind = kind;
    e.d = d;
    ev.push_back(e);
  endtask

  // Called right after a negedge. Line rules: 2-clock synchronizer plus
  // the detecting edge puts the start edge 3 clocks after rxd falls;
  // the deciding sample is 152 (or 168) ticks later.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input logic pbit);
    int         c0;
    int         nb;
    int         sat;
    logic       bad;
    logic [10:0] bits;
    c0 = cyc;
`ifdef BT_UART_RX_PARITY_EN
    bad = ((^d) != pbit);
    if (bad)
      add_ev(c0 + 155, 2, d);
    sat = c0 + 171;
    bits = {stop, pbit, d, 1'b0};
    nb = 11;
`else
    bad = 1'b0;
    sat = c0 + 155;
    bits = {pbit, stop, d, 1'b0};
    nb = 10;
`endif
    if (!stop)
      add_ev(sat, 1, d);
    else if (!bad)
      add_ev(sat, 0, d);
    for (int i = 0; i < nb; i++) begin
      rxd = bits[i];
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
  endtask

  always @(posedge clk) begin : model
    bit   popm;
    ev_t  e;
    cyc++;
    if (reset_n) begin
      if (clr_err) begin
        mf = 1'b0;
        mo = 1'b0;
        mp = 1'b0;
      end
      popm = out_ready && (mq.size() > 0);
      if (popm)
        void'(mq.pop_front());
      while (ev.size() > 0 && ev[0].at <= cyc) begin
        e = ev.pop_front();
        if (e.kind == 0) begin
          if (mq.size() < DEPTH)
            mq.push_back(e.d);
          else
            mo = 1'b1;
        end else if (e.kind == 1) begin
          mf = 1'b1;
        end else begin
          mp = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", out_valid, mq.size() != 0);
      chk("fifo_count", fifo_count, mq.size());
      if (mq.size() > 0)
        chk("out_data", out_data, mq[0]);
      chk("frame_err", frame_err, mf);
      chk("overrun", overrun, mo);
      chk("parity_err", parity_err, mp);
    end
  end

  always @(negedge clk) begin
    if (rand_on) begin
      out_ready = ($urandom_range(0, 99) < rp_pct);
      clr_err = ($urandom_range(0, 63) == 0);
    end
  end

  initial begin
    #600000;
    fails++;
    $display("FAIL timeout: got running, expected finished (cycle %0d)", cyc);
    summary();
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] d;
    logic       st;
    logic       pb;
    reset_n = 1'b0;
    rxd = 1'b1;
    out_ready = 1'b0;
    clr_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_fifo_count", fifo_count, 5'd0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_parity_err", parity_err, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    idle(5);

    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        repeat (STOP_AT - 1) @(negedge clk);
        chk("a5_before_push", out_valid, 1'b0);
        @(negedge clk);
        chk("a5_valid", out_valid, 1'b1);
        chk("a5_data", out_data, 8'hA5);
        chk("a5_count", fifo_count, 5'd1);
        chk("a5_flags", {frame_err, overrun, parity_err}, 3'b000);
      end
    join
    idle(4);

    rxd = 1'b0;
    repeat (4) @(negedge clk);
    idle(40);
    chk("glitch_count", fifo_count, 5'd1);
    chk("glitch_ferr", frame_err, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    chk("pop_a5_count", fifo_count, 5'd0);

    fork
      send_frame(8'h3C, 1'b0, 1'b0);
      begin
        repeat (STOP_AT - 1) @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
      end
    join
    idle(32);
    chk("ferr_set_wins", frame_err, 1'b1);
    chk("ferr_count", fifo_count, 5'd0);
    send_frame(8'h55, 1'b1, 1'b0);
    idle(4);
    chk("after_ferr_data", out_data, 8'h55);
    out_ready = 1'b1;
    clr_err = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    clr_err = 1'b0;
    @(negedge clk);
    chk("ferr_cleared", frame_err, 1'b0);

    for (int i = 0; i < 17; i++) begin
      d = 8'(i);
      send_frame(d, 1'b1, ^d);
    end
    idle(4);
    chk("ovr_count", fifo_count, 5'd16);
    chk("ovr_flag", overrun, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("ovr_order", out_data, 32'(i));
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("ovr_drained", fifo_count, 5'd0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("ovr_cleared", overrun, 1'b0);

    for (int i = 0; i < 16; i++) begin
      d = 8'h60 + 8'(i);
      send_frame(d, 1'b1, ^d);
    end
    fork
      send_frame(8'h77, 1'b1, 1'b1);
      begin
        repeat (STOP_AT - 1) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
      end
    join
    idle(4);
    chk("pp_count", fifo_count, 5'd16);
    chk("pp_overrun", overrun, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("pp_order", out_data, (i < 15) ? 32'(8'h61 + i) : 32'h77);
      @(negedge clk);
    end
    out_ready = 1'b0;

    send_frame(8'h42, 1'b1, 1'b0);
    idle(4);
    rxd = 1'b0;
    repeat (59) @(negedge clk);
    chk_en = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    reset_n = 1'b0;
    mq.delete();
    ev.delete();
    mf = 1'b0;
    mo = 1'b0;
    mp = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_count", fifo_count, 5'd0);
    chk("midrst_valid", out_valid, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    idle(8);
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(4);
    chk("midrst_next", out_data, 8'h5A);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

`ifdef BT_UART_RX_PARITY_EN
    send_frame(8'h01, 1'b1, 1'b0);
    idle(4);
    chk("par_bad_flag", parity_err, 1'b1);
    chk("par_bad_count", fifo_count, 5'd0);
    send_frame(8'h01, 1'b1, 1'b1);
    idle(4);
    chk("par_ok_data", out_data, 8'h01);
    chk("par_ok_count", fifo_count, 5'd1);
    out_ready = 1'b1;
    clr_err = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    clr_err = 1'b0;
`endif

    rand_on = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (n % 8 == 0)
        rp_pct = (n % 24 == 0) ? 0 : ((n % 24 == 8) ? 5 : 60);
      d = 8'($urandom);
      st = ($urandom_range(0, 7) != 0);
      pb = (^d) ^ ($urandom_range(0, 7) == 0);
      send_frame(d, st, pb);
      if (!st)
        idle(20);
      else
        idle($urandom_range(0, 2) * 8);
    end
    rand_on = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    clr_err = 1'b0;
    idle(40);
    chk("final_drain", fifo_count, 5'd0);
    summary();
    $finish;
  end
endmodule
